// File: rtl/piso_arbiter_if.sv
// piso_arbiter_if: requester, PISO and status signals shared by the arbiter and its environment
interface piso_arbiter_if #(parameter int NUM_REQ = 4);
   logic                   en;
   logic [NUM_REQ-1:0]     req;
   logic [2*NUM_REQ-1:0]   sym;
   logic [NUM_REQ-1:0]     ack;
   logic [NUM_REQ-1:0]     grant;
   logic [1:0]             piso_in;
   logic                   piso_valid;
   logic                   piso_done;
   logic                   busy;
   logic                   err_clr;
   logic                   timeout_err;
   modport master (input en, req, sym, piso_done, err_clr,
                   output ack, grant, piso_in, piso_valid, busy, timeout_err);
   modport slave  (output en, req, sym, piso_done, err_clr,
                   input ack, grant, piso_in, piso_valid, busy, timeout_err);
endinterface

// File: rtl/piso_arbiter.sv
// piso_arbiter: round-robin sequencer sharing one 2-bit PISO among NUM_REQ sources, with burst limit and watchdog
module piso_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int MAX_BURST = 4,
   parameter int TIMEOUT   = 15
) (
   input logic             clk,
   input logic             rst,
   piso_arbiter_if.master  bus
);
   localparam int IW = $clog2(NUM_REQ);
   localparam int BW = $clog2(MAX_BURST + 1);
   localparam int WW = $clog2(TIMEOUT);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;
   state_t             r_state, w_next;
   logic [IW-1:0]      r_ptr, r_owner, r_last_owner, w_ptr_eff, w_win, w_owner_inc;
   logic [BW-1:0]      r_burst_cnt, w_burst_inc;
   logic [WW-1:0]      r_wd_cnt;
   logic [NUM_REQ-1:0] r_grant;
   logic [1:0]         r_piso_in;
   logic               r_timeout_err, w_cont, w_found, w_start, w_timeout;

   function automatic logic [IW-1:0] wrap(input int v);
      return IW'(v >= NUM_REQ ? v - NUM_REQ : v);
   endfunction

   // winner: an unfinished burst keeps the owner; a dropped burst rotates past its owner; else circular search
   always_comb begin
      w_cont      = r_burst_cnt != '0 && r_burst_cnt < BW'(MAX_BURST) && bus.req[r_last_owner];
      w_ptr_eff   = (r_burst_cnt != '0 && !bus.req[r_last_owner]) ? wrap(int'(r_last_owner) + 1) : r_ptr;
      w_owner_inc = wrap(int'(r_owner) + 1);
      w_burst_inc = (r_owner == r_last_owner) ? r_burst_cnt + 1'b1 : BW'(1);
      w_found     = 1'b0;
      w_win       = w_ptr_eff;
      for (int k = 0; k < NUM_REQ; k++)
         if (!w_found && bus.req[wrap(int'(w_ptr_eff) + k)]) begin
            w_found = 1'b1;
            w_win   = wrap(int'(w_ptr_eff) + k);
         end
      if (w_cont) w_win = r_last_owner;
   end

   // next state; piso_done beats a coincident timeout
   always_comb begin
      w_next    = r_state;
      w_start   = 1'b0;
      w_timeout = 1'b0;
      case (r_state)
         IDLE:  if (bus.en && w_found) begin
                   w_start = 1'b1;
                   w_next  = ISSUE;
                end
         ISSUE: w_next = WAIT;
         WAIT:  if (bus.piso_done) w_next = ACK;
                else if (r_wd_cnt == WW'(TIMEOUT - 1)) begin
                   w_timeout = 1'b1;
                   w_next    = IDLE;
                end
         default: w_next = IDLE;
      endcase
   end

   // state register
   always_ff @(posedge clk or posedge rst)
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;

   // grant latch, watchdog count, burst and pointer bookkeeping, sticky error flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ptr         <= '0;
         r_owner       <= '0;
         r_last_owner  <= '0;
         r_burst_cnt   <= '0;
         r_wd_cnt      <= '0;
         r_grant       <= '0;
         r_piso_in     <= '0;
         r_timeout_err <= 1'b0;
      end else begin
         case (r_state)
            IDLE:  if (w_start) begin
                      r_owner   <= w_win;
                      r_grant   <= NUM_REQ'(1) << w_win;
                      r_piso_in <= bus.sym[2*w_win +: 2];
                      r_ptr     <= w_ptr_eff;
                   end
            ISSUE: r_wd_cnt <= '0;
            WAIT:  if (w_timeout) begin
                      r_burst_cnt <= '0;
                      r_ptr       <= w_owner_inc;
                      r_grant     <= '0;
                   end else if (!bus.piso_done) r_wd_cnt <= r_wd_cnt + 1'b1;
            ACK:   begin
                      r_grant      <= '0;
                      r_last_owner <= r_owner;
                      if (w_burst_inc == BW'(MAX_BURST)) begin
                         r_burst_cnt <= '0;
                         r_ptr       <= w_owner_inc;
                      end else r_burst_cnt <= w_burst_inc;
                   end
         endcase
         r_timeout_err <= w_timeout | (r_timeout_err & ~bus.err_clr);
      end
   end

   assign bus.grant       = r_grant;
   assign bus.piso_in     = r_piso_in;
   assign bus.piso_valid  = r_state == ISSUE;
   assign bus.busy        = r_state != IDLE;
   assign bus.ack         = (r_state == ACK) ? r_grant : '0;
   assign bus.timeout_err = r_timeout_err;
endmodule

// File: tb/tb_piso_arbiter.sv
// tb_piso_arbiter: directed tests of the PISO arbiter against hand-computed cycle timelines
module tb_piso_arbiter;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   int         n_tests = 0;
   int         n_fail = 0;
   int         delay = 3;
   logic [4:0] pc, pc_r;

   piso_arbiter_if #(.NUM_REQ(4)) bi();
   piso_arbiter_if #(.NUM_REQ(4)) br();

   piso_arbiter #(.NUM_REQ(4), .MAX_BURST(4), .TIMEOUT(15)) u_dut (.clk(clk), .rst(rst), .bus(bi));
   piso_arbiter #(.NUM_REQ(4), .MAX_BURST(1), .TIMEOUT(15)) u_rr  (.clk(clk), .rst(rst), .bus(br));

   always #5 clk = ~clk;

   // PISO stand-in for u_dut: done 'delay' cycles after the valid pulse, never when delay is 0
   always @(posedge clk or posedge rst)
      if (rst) pc <= '0;
      else if (bi.piso_valid) pc <= 5'd1;
      else if (bi.piso_done) pc <= '0;
      else if (pc != '0) pc <= pc + 5'd1;
   assign bi.piso_done = delay != 0 && pc == 5'(delay);

   // nominal PISO stand-in for u_rr
   always @(posedge clk or posedge rst)
      if (rst) pc_r <= '0;
      else if (br.piso_valid) pc_r <= 5'd1;
      else if (br.piso_done) pc_r <= '0;
      else if (pc_r != '0) pc_r <= pc_r + 5'd1;
   assign br.piso_done = pc_r == 5'd3;

   task automatic do_reset;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic wait_ack(output int idx, output int cyc);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (bi.ack === 4'b0 && cyc < 40);
      idx = -1;
      for (int k = 0; k < 4; k++) if (bi.ack[k]) idx = k;
   endtask

   task automatic test_reset;
      @(negedge clk);
      n_tests++;
      if ({bi.ack, bi.grant, bi.piso_in, bi.piso_valid, bi.busy, bi.timeout_err} !== 15'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %b want 0", {bi.ack, bi.grant, bi.piso_in, bi.piso_valid, bi.busy, bi.timeout_err});
      end
      n_tests++;
      if ({br.ack, br.grant, br.piso_in, br.piso_valid, br.busy, br.timeout_err} !== 15'b0) begin
         n_fail++;
         $display("FAIL reset_outputs_rr: got %b want 0", {br.ack, br.grant, br.piso_in, br.piso_valid, br.busy, br.timeout_err});
      end
      rst = 1'b0;
   endtask

   task automatic test_single;
      int idx, cyc;
      do_reset();
      bi.req = 4'b0001;
      bi.sym = 8'b0000_0010;
      @(negedge clk);
      n_tests++;
      if ({bi.piso_valid, bi.piso_in, bi.grant} !== 7'b1_10_0001) begin
         n_fail++;
         $display("FAIL single_issue: valid/piso_in/grant got %b want 1_10_0001", {bi.piso_valid, bi.piso_in, bi.grant});
      end
      @(negedge clk);
      n_tests++;
      if ({bi.piso_valid, bi.busy, bi.grant} !== 6'b0_1_0001) begin
         n_fail++;
         $display("FAIL single_wait: valid/busy/grant got %b want 0_1_0001", {bi.piso_valid, bi.busy, bi.grant});
      end
      wait_ack(idx, cyc);
      n_tests++;
      if (cyc + 2 != 5 || bi.ack !== 4'b0001) begin
         n_fail++;
         $display("FAIL single_ack: latency %0d ack %b want 5 0001", cyc + 2, bi.ack);
      end
      n_tests++;
      if (bi.grant !== 4'b0001 || bi.piso_in !== 2'b10) begin
         n_fail++;
         $display("FAIL single_ack_hold: grant %b piso_in %b want 0001 10", bi.grant, bi.piso_in);
      end
      bi.req = 4'b0;
      @(negedge clk);
      n_tests++;
      if ({bi.grant, bi.busy, bi.ack} !== 9'b0) begin
         n_fail++;
         $display("FAIL single_idle: grant/busy/ack got %b want 0", {bi.grant, bi.busy, bi.ack});
      end
   endtask

   task automatic test_round_robin;
      int e[5] = '{0, 1, 2, 3, 0};
      logic [7:0] s = 8'b11_10_01_00;
      int idx, cyc;
      do_reset();
      br.req = 4'b1111;
      br.sym = s;
      for (int i = 0; i < 5; i++) begin
         cyc = 0;
         do begin
            @(negedge clk);
            cyc++;
         end while (br.ack === 4'b0 && cyc < 40);
         idx = -1;
         for (int k = 0; k < 4; k++) if (br.ack[k]) idx = k;
         n_tests++;
         if (idx != e[i]) begin
            n_fail++;
            $display("FAIL rr_order[%0d]: got %0d want %0d", i, idx, e[i]);
         end
         n_tests++;
         if (br.piso_in !== s[2*e[i] +: 2]) begin
            n_fail++;
            $display("FAIL rr_sym[%0d]: got %b want %b", i, br.piso_in, s[2*e[i] +: 2]);
         end
         n_tests++;
         if (cyc != (i == 0 ? 5 : 6)) begin
            n_fail++;
            $display("FAIL rr_spacing[%0d]: got %0d want %0d", i, cyc, i == 0 ? 5 : 6);
         end
      end
      br.req = 4'b0;
   endtask

   task automatic test_burst;
      int e[9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
      logic [7:0] s = 8'b0000_0111;
      int idx, cyc;
      do_reset();
      bi.req = 4'b0011;
      bi.sym = s;
      for (int i = 0; i < 9; i++) begin
         wait_ack(idx, cyc);
         n_tests++;
         if (idx != e[i] || bi.piso_in !== s[2*e[i] +: 2]) begin
            n_fail++;
            $display("FAIL burst[%0d]: ack %0d sym %b want %0d %b", i, idx, bi.piso_in, e[i], s[2*e[i] +: 2]);
         end
      end
      bi.req = 4'b0;
   endtask

   task automatic test_burst_drop;
      int idx, cyc;
      do_reset();
      bi.req = 4'b0011;
      bi.sym = 8'b0000_0111;
      for (int i = 0; i < 2; i++) begin
         wait_ack(idx, cyc);
         n_tests++;
         if (idx != 0) begin
            n_fail++;
            $display("FAIL drop_pre[%0d]: got %0d want 0", i, idx);
         end
      end
      bi.req = 4'b0010;
      wait_ack(idx, cyc);
      n_tests++;
      if (idx != 1 || cyc != 6 || bi.piso_in !== 2'b01) begin
         n_fail++;
         $display("FAIL drop_next: ack %0d after %0d sym %b want 1 6 01", idx, cyc, bi.piso_in);
      end
      bi.req = 4'b0;
   endtask

   task automatic test_watchdog;
      int c = 0;
      bit acked = 0;
      do_reset();
      delay = 0;
      bi.req = 4'b0011;
      @(negedge clk);
      n_tests++;
      if (bi.piso_valid !== 1'b1 || bi.grant !== 4'b0001) begin
         n_fail++;
         $display("FAIL wd_issue: valid %b grant %b want 1 0001", bi.piso_valid, bi.grant);
      end
      do begin
         @(negedge clk);
         c++;
         if (bi.ack !== 4'b0) acked = 1;
      end while (bi.timeout_err !== 1'b1 && c < 40);
      n_tests++;
      if (c != 16 || acked || bi.grant !== 4'b0 || bi.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL wd_timeout: cycles %0d acked %0d grant %b busy %b want 16 0 0000 0", c, acked, bi.grant, bi.busy);
      end
      @(negedge clk);
      n_tests++;
      if (bi.grant !== 4'b0010) begin
         n_fail++;
         $display("FAIL wd_next_grant: got %b want 0010", bi.grant);
      end
      bi.err_clr = 1'b1;
      @(negedge clk);
      bi.err_clr = 1'b0;
      n_tests++;
      if (bi.timeout_err !== 1'b0) begin
         n_fail++;
         $display("FAIL wd_clear: got %b want 0", bi.timeout_err);
      end
      repeat (14) @(negedge clk);
      bi.err_clr = 1'b1;
      @(negedge clk);
      bi.err_clr = 1'b0;
      n_tests++;
      if (bi.timeout_err !== 1'b1 || bi.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL wd_set_priority: err %b busy %b want 1 0", bi.timeout_err, bi.busy);
      end
      bi.req = 4'b0;
      delay = 3;
   endtask

   task automatic test_enable;
      int idx, cyc;
      bit seen = 0;
      do_reset();
      bi.en = 1'b0;
      bi.req = 4'b0100;
      bi.sym = 8'b0010_0000;
      repeat (6) begin
         @(negedge clk);
         if (bi.piso_valid !== 1'b0 || bi.busy !== 1'b0) seen = 1;
      end
      n_tests++;
      if (seen) begin
         n_fail++;
         $display("FAIL en_low: activity seen 1 want 0");
      end
      bi.en = 1'b1;
      @(negedge clk);
      n_tests++;
      if (bi.grant !== 4'b0100 || bi.piso_valid !== 1'b1 || bi.piso_in !== 2'b10) begin
         n_fail++;
         $display("FAIL en_grant: grant %b valid %b sym %b want 0100 1 10", bi.grant, bi.piso_valid, bi.piso_in);
      end
      bi.en = 1'b0;
      wait_ack(idx, cyc);
      n_tests++;
      if (idx != 2 || cyc != 4) begin
         n_fail++;
         $display("FAIL en_inflight: ack %0d after %0d want 2 4", idx, cyc);
      end
      bi.req = 4'b0;
      bi.en = 1'b1;
   endtask

   task automatic test_reset_mid;
      int idx, cyc;
      do_reset();
      bi.req = 4'b0001;
      bi.sym = 8'b0000_0001;
      repeat (4) wait_ack(idx, cyc);
      bi.req = 4'b0011;
      repeat (2) @(negedge clk);
      n_tests++;
      if (bi.grant !== 4'b0010) begin
         n_fail++;
         $display("FAIL rst_pre_grant: got %b want 0010", bi.grant);
      end
      @(negedge clk);
      rst = 1'b1;
      #1;
      n_tests++;
      if ({bi.ack, bi.grant, bi.piso_in, bi.piso_valid, bi.busy, bi.timeout_err} !== 15'b0) begin
         n_fail++;
         $display("FAIL rst_async: got %b want 0", {bi.ack, bi.grant, bi.piso_in, bi.piso_valid, bi.busy, bi.timeout_err});
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      n_tests++;
      if (bi.grant !== 4'b0001) begin
         n_fail++;
         $display("FAIL rst_priority: got %b want 0001", bi.grant);
      end
      bi.req = 4'b0;
      wait_ack(idx, cyc);
   endtask

   task automatic test_collision;
      int idx, cyc;
      do_reset();
      delay = 15;
      bi.req = 4'b0001;
      wait_ack(idx, cyc);
      n_tests++;
      if (idx != 0 || cyc != 17) begin
         n_fail++;
         $display("FAIL collide_ack: ack %0d after %0d want 0 17", idx, cyc);
      end
      bi.req = 4'b0;
      @(negedge clk);
      n_tests++;
      if (bi.timeout_err !== 1'b0) begin
         n_fail++;
         $display("FAIL collide_err: got %b want 0", bi.timeout_err);
      end
      delay = 3;
   endtask

   // test sequence
   initial begin
      bi.en = 1'b1; bi.req = '0; bi.sym = '0; bi.err_clr = 1'b0;
      br.en = 1'b1; br.req = '0; br.sym = '0; br.err_clr = 1'b0;
      test_reset();
      test_single();
      test_round_robin();
      test_burst();
      test_burst_drop();
      test_watchdog();
      test_enable();
      test_reset_mid();
      test_collision();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
